// File: rtl/rot_apb_pkg.sv
// Register map constants, CTRL bit positions and rotation-mode encoding for the
// rotation engine APB register file.
package rot_apb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned DIM_W  = 16;

    // Word indices (PADDR[7:2]) of the mapped registers
    localparam logic [IDX_W-1:0] IDX_DMA_SRC  = IDX_W'(6'h00);
    localparam logic [IDX_W-1:0] IDX_DMA_DST  = IDX_W'(6'h01);
    localparam logic [IDX_W-1:0] IDX_IMG_SIZE = IDX_W'(6'h02);
    localparam logic [IDX_W-1:0] IDX_IMG_NEW  = IDX_W'(6'h03);
    localparam logic [IDX_W-1:0] IDX_ROT_CFG  = IDX_W'(6'h04);
    localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(6'h05);
    localparam logic [IDX_W-1:0] IDX_ID       = IDX_W'(6'h06);

    localparam int unsigned CTRL_START_BIT      = 0;
    localparam int unsigned CTRL_RESET_BIT      = 1;
    localparam int unsigned CTRL_INTR_MASK_BIT  = 2;
    localparam int unsigned CTRL_INTR_CLEAR_BIT = 3;
    localparam int unsigned CTRL_BEF_MASK_BIT   = 4;
    localparam int unsigned CTRL_AFT_MASK_BIT   = 5;
    localparam int unsigned CTRL_BUSY_BIT       = 6;

    localparam int unsigned CFG_DIR_BIT = 2;

    localparam logic [DATA_W-1:0] ROT_APB_ID = DATA_W'(32'h524F_5401);

    typedef enum logic [1:0] {
        ROT_MODE_0   = 2'd0,
        ROT_MODE_90  = 2'd1,
        ROT_MODE_180 = 2'd2,
        ROT_MODE_270 = 2'd3
    } rot_mode_e;

    // Addresses above the 256-byte window are never decoded
    function automatic logic addr_in_window(input logic [ADDR_W-1:0] paddr);
        return (paddr[ADDR_W-1:8] == 24'd0);
    endfunction

endpackage

// File: rtl/rot_apb_regif.sv
// Zero-wait-state APB register file for the image-rotation engine.
// Optional ROT_APB_ID_REG_EN adds a read-only ID register at 0x18.
module rot_apb_regif
    import rot_apb_pkg::*;
(
    input  logic        I_PCLK,
    input  logic        I_PRESET_N,
    input  logic        I_PSEL,
    input  logic        I_PENABLE,
    input  logic        I_PWRITE,
    input  logic [31:0] I_PADDR,
    input  logic [31:0] I_PWDATA,
    output logic [31:0] O_PRDATA,
    output logic        O_PREADY,
    input  logic [15:0] I_ROT_IMG_NEW_H,
    input  logic [15:0] I_ROT_IMG_NEW_W,
    input  logic        I_CTRL_BEF_MASK,
    input  logic        I_CTRL_AFT_MASK,
    input  logic        I_CTRL_BUSY,
    output logic [31:0] O_DMA_SRC_IMG,
    output logic [31:0] O_DMA_DST_IMG,
    output logic [15:0] O_ROT_IMG_H,
    output logic [15:0] O_ROT_IMG_W,
    output logic [15:0] O_ROT_IMG_NEW_H,
    output logic [15:0] O_ROT_IMG_NEW_W,
    output logic [1:0]  O_ROT_IMG_MODE,
    output logic        O_ROT_IMG_DIR,
    output logic        O_CTRL_START,
    output logic        O_CTRL_RESET,
    output logic        O_CTRL_INTR_MASK,
    output logic        O_CTRL_BEF_MASK,
    output logic        O_CTRL_AFT_MASK,
    output logic        O_CTRL_INTR_CLEAR,
    output logic        O_CTRL_BUSY
);

    logic [DATA_W-1:0] dma_src_q, dma_src_d;
    logic [DATA_W-1:0] dma_dst_q, dma_dst_d;
    logic [DIM_W-1:0]  img_h_q, img_h_d;
    logic [DIM_W-1:0]  img_w_q, img_w_d;
    logic [DIM_W-1:0]  new_h_q, new_h_d;
    logic [DIM_W-1:0]  new_w_q, new_w_d;
    rot_mode_e         mode_q, mode_d;
    logic              dir_q, dir_d;
    logic              start_q, start_d;
    logic              soft_rst_q, soft_rst_d;
    logic              intr_mask_q, intr_mask_d;
    logic              intr_clr_q, intr_clr_d;
    logic              bef_mask_q, bef_mask_d;
    logic              aft_mask_q, aft_mask_d;
    logic              busy_q, busy_d;

    logic              in_window_c;
    logic [IDX_W-1:0]  idx_c;
    logic              wr_en_c;
    logic              rd_en_c;
    logic [DATA_W-1:0] rd_mux_c;
    logic              unused_paddr_c;

    assign in_window_c    = addr_in_window(I_PADDR);
    assign idx_c          = I_PADDR[7:2];
    assign wr_en_c        = I_PSEL & I_PENABLE & I_PWRITE & in_window_c;
    assign rd_en_c        = I_PSEL & ~I_PWRITE & in_window_c;
    assign unused_paddr_c = ^I_PADDR[1:0];

    assign O_PREADY = I_PSEL & I_PENABLE;

    // Next-state: register writes, one-shot control pulses, status sampling
    always_comb begin
        dma_src_d   = dma_src_q;
        dma_dst_d   = dma_dst_q;
        img_h_d     = img_h_q;
        img_w_d     = img_w_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        intr_mask_d = intr_mask_q;
        start_d     = 1'b0;
        soft_rst_d  = 1'b0;
        intr_clr_d  = 1'b0;
        new_h_d     = I_ROT_IMG_NEW_H;
        new_w_d     = I_ROT_IMG_NEW_W;
        bef_mask_d  = I_CTRL_BEF_MASK;
        aft_mask_d  = I_CTRL_AFT_MASK;
        busy_d      = I_CTRL_BUSY;

        if (wr_en_c) begin
            case (idx_c)
                IDX_DMA_SRC:  dma_src_d = I_PWDATA;
                IDX_DMA_DST:  dma_dst_d = I_PWDATA;
                IDX_IMG_SIZE: begin
                    img_h_d = I_PWDATA[31:16];
                    img_w_d = I_PWDATA[15:0];
                end
                IDX_ROT_CFG: begin
                    mode_d = rot_mode_e'(I_PWDATA[1:0]);
                    dir_d  = I_PWDATA[CFG_DIR_BIT];
                end
                IDX_CTRL: begin
                    // A soft reset wins over start; start is also dropped while busy
                    soft_rst_d  = I_PWDATA[CTRL_RESET_BIT];
                    start_d     = I_PWDATA[CTRL_START_BIT] & ~I_PWDATA[CTRL_RESET_BIT] & ~busy_q;
                    intr_clr_d  = I_PWDATA[CTRL_INTR_CLEAR_BIT];
                    intr_mask_d = I_PWDATA[CTRL_INTR_MASK_BIT];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
        if (!I_PRESET_N) begin
            dma_src_q   <= '0;
            dma_dst_q   <= '0;
            img_h_q     <= '0;
            img_w_q     <= '0;
            new_h_q     <= '0;
            new_w_q     <= '0;
            mode_q      <= ROT_MODE_0;
            dir_q       <= 1'b0;
            start_q     <= 1'b0;
            soft_rst_q  <= 1'b0;
            intr_mask_q <= 1'b0;
            intr_clr_q  <= 1'b0;
            bef_mask_q  <= 1'b0;
            aft_mask_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            dma_src_q   <= dma_src_d;
            dma_dst_q   <= dma_dst_d;
            img_h_q     <= img_h_d;
            img_w_q     <= img_w_d;
            new_h_q     <= new_h_d;
            new_w_q     <= new_w_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            start_q     <= start_d;
            soft_rst_q  <= soft_rst_d;
            intr_mask_q <= intr_mask_d;
            intr_clr_q  <= intr_clr_d;
            bef_mask_q  <= bef_mask_d;
            aft_mask_q  <= aft_mask_d;
            busy_q      <= busy_d;
        end
    end

    // Read mux; write-one-pulse bits and unused bits read as zero
    always_comb begin
        rd_mux_c = '0;
        case (idx_c)
            IDX_DMA_SRC:  rd_mux_c = dma_src_q;
            IDX_DMA_DST:  rd_mux_c = dma_dst_q;
            IDX_IMG_SIZE: rd_mux_c = {img_h_q, img_w_q};
            IDX_IMG_NEW:  rd_mux_c = {new_h_q, new_w_q};
            IDX_ROT_CFG: begin
                rd_mux_c[1:0]         = mode_q;
                rd_mux_c[CFG_DIR_BIT] = dir_q;
            end
            IDX_CTRL: begin
                rd_mux_c[CTRL_INTR_MASK_BIT] = intr_mask_q;
                rd_mux_c[CTRL_BEF_MASK_BIT]  = bef_mask_q;
                rd_mux_c[CTRL_AFT_MASK_BIT]  = aft_mask_q;
                rd_mux_c[CTRL_BUSY_BIT]      = busy_q;
            end
`ifdef ROT_APB_ID_REG_EN
            IDX_ID:       rd_mux_c = ROT_APB_ID;
`endif
            default:      rd_mux_c = '0;
        endcase
    end

    assign O_PRDATA = rd_en_c ? rd_mux_c : '0;

    assign O_DMA_SRC_IMG     = dma_src_q;
    assign O_DMA_DST_IMG     = dma_dst_q;
    assign O_ROT_IMG_H       = img_h_q;
    assign O_ROT_IMG_W       = img_w_q;
    assign O_ROT_IMG_NEW_H   = new_h_q;
    assign O_ROT_IMG_NEW_W   = new_w_q;
    assign O_ROT_IMG_MODE    = mode_q;
    assign O_ROT_IMG_DIR     = dir_q;
    assign O_CTRL_START      = start_q;
    assign O_CTRL_RESET      = soft_rst_q;
    assign O_CTRL_INTR_MASK  = intr_mask_q;
    assign O_CTRL_BEF_MASK   = bef_mask_q;
    assign O_CTRL_AFT_MASK   = aft_mask_q;
    assign O_CTRL_INTR_CLEAR = intr_clr_q;
    assign O_CTRL_BUSY       = busy_q;

endmodule

// File: tb/tb_rot_apb_regif.sv
// Directed self-checking bench for rot_apb_regif; expected values are hand-derived.
`timescale 1ns/1ps
module tb_rot_apb_regif;

    logic        clk;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic [15:0] new_h_in, new_w_in;
    logic        bef_in, aft_in, busy_in;
    logic [31:0] dma_src, dma_dst;
    logic [15:0] img_h, img_w, img_new_h, img_new_w;
    logic [1:0]  img_mode;
    logic        img_dir, ctrl_start, ctrl_reset, intr_mask, bef_out, aft_out, intr_clear, busy_out;

    int n_tests;
    int n_fail;

    rot_apb_regif dut (
        .I_PCLK            (clk),
        .I_PRESET_N        (rst_n),
        .I_PSEL            (psel),
        .I_PENABLE         (penable),
        .I_PWRITE          (pwrite),
        .I_PADDR           (paddr),
        .I_PWDATA          (pwdata),
        .O_PRDATA          (prdata),
        .O_PREADY          (pready),
        .I_ROT_IMG_NEW_H   (new_h_in),
        .I_ROT_IMG_NEW_W   (new_w_in),
        .I_CTRL_BEF_MASK   (bef_in),
        .I_CTRL_AFT_MASK   (aft_in),
        .I_CTRL_BUSY       (busy_in),
        .O_DMA_SRC_IMG     (dma_src),
        .O_DMA_DST_IMG     (dma_dst),
        .O_ROT_IMG_H       (img_h),
        .O_ROT_IMG_W       (img_w),
        .O_ROT_IMG_NEW_H   (img_new_h),
        .O_ROT_IMG_NEW_W   (img_new_w),
        .O_ROT_IMG_MODE    (img_mode),
        .O_ROT_IMG_DIR     (img_dir),
        .O_CTRL_START      (ctrl_start),
        .O_CTRL_RESET      (ctrl_reset),
        .O_CTRL_INTR_MASK  (intr_mask),
        .O_CTRL_BEF_MASK   (bef_out),
        .O_CTRL_AFT_MASK   (aft_out),
        .O_CTRL_INTR_CLEAR (intr_clear),
        .O_CTRL_BUSY       (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Setup at one negedge, access at the next; the commit edge lies between
    // the access negedge and the negedge on which this task returns.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge clk);
        penable = 1'b1;
        #1;
        data = prdata;
        rdy  = pready;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        rdy;
    logic [31:0] exp_id;

    initial begin
        n_tests = 0; n_fail = 0;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        new_h_in = 0; new_w_in = 0; bef_in = 0; aft_in = 0; busy_in = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state: outputs and every mapped read are zero
        repeat (2) @(negedge clk);
        chk("rst_src", dma_src, 32'h0);
        chk("rst_dst", dma_dst, 32'h0);
        chk("rst_size", {img_h, img_w}, 32'h0);
        chk("rst_cfg", {29'd0, img_dir, img_mode}, 32'h0);
        chk("rst_ctrl", {25'd0, busy_out, intr_clear, aft_out, bef_out, intr_mask, ctrl_reset, ctrl_start}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            apb_read(32'(i * 4), rd, rdy);
            chk($sformatf("rst_rd_%0d", i), rd, 32'h0);
        end
        rst_n = 1'b1;

        // DMA addresses, readback and byte-offset aliasing
        apb_write(32'h00, 32'd20);
        apb_write(32'h04, 32'd7000);
        chk("src_out", dma_src, 32'd20);
        chk("dst_out", dma_dst, 32'd7000);
        apb_read(32'h00, rd, rdy);
        chk("src_rd", rd, 32'd20);
        chk("src_pready", {31'd0, rdy}, 32'h1);
        apb_read(32'h04, rd, rdy);
        chk("dst_rd", rd, 32'd7000);
        apb_read(32'h01, rd, rdy);
        chk("alias_rd", rd, 32'd20);

        // Geometry and rotation config
        apb_write(32'h08, 32'h0020_0040);
        apb_write(32'h10, 32'h0000_0005);
        chk("img_h", {16'd0, img_h}, 32'd32);
        chk("img_w", {16'd0, img_w}, 32'd64);
        chk("mode", {30'd0, img_mode}, 32'd1);
        chk("dir", {31'd0, img_dir}, 32'd1);
        apb_read(32'h10, rd, rdy);
        chk("cfg_rd", rd, 32'h5);
        apb_read(32'h08, rd, rdy);
        chk("size_rd", rd, 32'h0020_0040);

        // START pulse while idle: high for one cycle only
        apb_write(32'h14, 32'h1);
        chk("start_pulse", {31'd0, ctrl_start}, 32'h1);
        @(negedge clk);
        chk("start_clear", {31'd0, ctrl_start}, 32'h0);

        // START while busy is dropped
        busy_in = 1'b1;
        repeat (2) @(negedge clk);
        apb_write(32'h14, 32'h1);
        chk("start_busy0", {31'd0, ctrl_start}, 32'h0);
        @(negedge clk);
        chk("start_busy1", {31'd0, ctrl_start}, 32'h0);

        // Status readback
        new_h_in = 16'h0040; new_w_in = 16'h0020; bef_in = 1'b1;
        @(negedge clk);
        chk("new_h_out", {16'd0, img_new_h}, 32'h40);
        chk("new_w_out", {16'd0, img_new_w}, 32'h20);
        apb_read(32'h0C, rd, rdy);
        chk("new_rd", rd, 32'h0040_0020);
        apb_read(32'h14, rd, rdy);
        chk("ctrl_rd_busy", rd, 32'h50);

        // RESET and INTR_CLEAR pulse even while busy; RESET suppresses START
        apb_write(32'h14, 32'h8);
        chk("clr_pulse", {31'd0, intr_clear}, 32'h1);
        @(negedge clk);
        chk("clr_clear", {31'd0, intr_clear}, 32'h0);
        busy_in = 1'b0;
        repeat (2) @(negedge clk);
        apb_write(32'h14, 32'h3);
        chk("sr_reset", {31'd0, ctrl_reset}, 32'h1);
        chk("sr_start", {31'd0, ctrl_start}, 32'h0);
        @(negedge clk);
        chk("sr_reset_clr", {31'd0, ctrl_reset}, 32'h0);

        // Interrupt mask is plain RW and shares the CTRL readback
        apb_write(32'h14, 32'h4);
        chk("mask_out", {31'd0, intr_mask}, 32'h1);
        chk("mask_start", {31'd0, ctrl_start}, 32'h0);
        apb_read(32'h14, rd, rdy);
        chk("ctrl_rd_mask", rd, 32'h14);

        // Unmapped address: no register change, reads zero, still ready
        apb_write(32'h1B58, 32'hFFFF_FFFF);
        chk("unm_src", dma_src, 32'd20);
        chk("unm_dst", dma_dst, 32'd7000);
        chk("unm_size", {img_h, img_w}, 32'h0020_0040);
        apb_read(32'h1B58, rd, rdy);
        chk("unm_rd", rd, 32'h0);
        chk("unm_pready", {31'd0, rdy}, 32'h1);
        apb_write(32'h100, 32'h0000_1234);
        chk("unm_hi_src", dma_src, 32'd20);

        // Optional ID register at 0x18
`ifdef ROT_APB_ID_REG_EN
        exp_id = 32'h524F_5401;
`else
        exp_id = 32'h0;
`endif
        apb_write(32'h18, 32'h1234_5678);
        apb_read(32'h18, rd, rdy);
        chk("id_rd", rd, exp_id);

        // PRDATA is zero when not selected
        paddr = 32'h0;
        #1;
        chk("prdata_idle", prdata, 32'h0);

        // Reset asserted mid-transfer clears state at once and loses the write
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hDEAD_BEEF;
        @(negedge clk);
        penable = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_src", dma_src, 32'h0);
        chk("mid_rst_mask", {31'd0, intr_mask}, 32'h0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_dst", dma_dst, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
